// File: rtl/dcache_pkg.sv
// Shared FSM state type, default line geometry and address-field width helpers
// for the direct-mapped write-back L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    RESUME
  } state_e;

  localparam int DEF_LINE_BYTES = 32;
  localparam int LINE_W         = DEF_LINE_BYTES * 8;
  localparam int WORDS_PER_LINE = DEF_LINE_BYTES / 4;

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int line_bytes);
    return addr_w - $clog2(num_lines) - $clog2(line_bytes);
  endfunction

  // A single-word line still gets a 1-bit word select so no field is zero-width.
  function automatic int wsel_w(input int line_bytes);
    return (line_bytes > 4) ? $clog2(line_bytes) - 2 : 1;
  endfunction

  function automatic int line_w(input int line_bytes);
    return line_bytes * 8;
  endfunction

  function automatic int words_per_line(input int line_bytes);
    return line_bytes / 4;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Bundle of the MEM-stage request/response and backing-memory handshake signals.
// The slave modport is the cache controller; master is the pipeline plus memory side.
interface dcache_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32
);
  localparam int LW = LINE_BYTES * 8;

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LW-1:0]     mem_wdata_o;
  logic [LW-1:0]     mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one combinational read port and
// one synchronous write port sharing the same line index.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32,
  localparam int IDX_W  = index_w(NUM_LINES),
  localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, LINE_BYTES),
  localparam int WSEL_W = wsel_w(LINE_BYTES),
  localparam int LW     = line_w(LINE_BYTES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LW-1:0]     rd_line_o,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LW-1:0]     line_data_i,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [31:0]       word_data_i,
  input  logic              clean_i
);

  logic [NUM_LINES-1:0] valid_vec;
  logic [NUM_LINES-1:0] dirty_vec;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LW-1:0]        data_q [NUM_LINES];

  // Status bits live in flops so reset can clear every line in one cycle.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    logic valid_q, valid_d;
    logic dirty_q, dirty_d;
    logic sel;

    assign sel = (idx_i == IDX_W'(gi));

    always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (sel) begin
        if (line_we_i) begin
          valid_d = 1'b1;
          dirty_d = 1'b0;
        end
        if (word_we_i) dirty_d = 1'b1;
        if (clean_i)   dirty_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        dirty_q <= dirty_d;
      end
    end

    assign valid_vec[gi] = valid_q;
    assign dirty_vec[gi] = dirty_q;
  end

  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][32*word_sel_i +: 32] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_vec[idx_i];
  assign rd_dirty_o = dirty_vec[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller (FSM, hit logic,
// memory handshake). Define DCACHE_STATS_EN to add hit/miss/writeback counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o
`endif
);

  localparam int OFF_W  = offset_w(LINE_BYTES);
  localparam int IDX_W  = index_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, LINE_BYTES);
  localparam int WSEL_W = wsel_w(LINE_BYTES);
  localparam int LW     = line_w(LINE_BYTES);
  localparam int WORDS  = words_per_line(LINE_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              replay_q, replay_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]     mem_wdata_q, mem_wdata_d;

  // Live pipeline inputs on a first look; the latched miss request while servicing
  // it and during the replay cycle straight after RESUME.
  logic              use_latched;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [31:0]       acc_wdata;
  logic [TAG_W-1:0]  acc_tag;
  logic [IDX_W-1:0]  acc_idx;
  logic [WSEL_W-1:0] acc_wsel;

  assign use_latched = (state_q != IDLE) || replay_q;
  assign acc_addr    = use_latched ? addr_q  : bus.cpu_addr_i;
  assign acc_we      = use_latched ? we_q    : bus.cpu_we_i;
  assign acc_wdata   = use_latched ? wdata_q : bus.cpu_wdata_i;
  assign acc_tag     = acc_addr[ADDR_W-1 -: TAG_W];
  assign acc_idx     = acc_addr[OFF_W +: IDX_W];
  assign acc_wsel    = WSEL_W'((acc_addr >> 2) & ADDR_W'(WORDS - 1));

  logic             rd_valid, rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  logic [LW-1:0]    rd_line;
  logic             line_we, word_we, clean;
  logic             hit;
  logic             stall;
  logic [31:0]      rdata;

  dcache_sram #(
    .NUM_LINES  (NUM_LINES),
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (acc_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .line_we_i   (line_we),
    .line_tag_i  (acc_tag),
    .line_data_i (bus.mem_rdata_i),
    .word_we_i   (word_we),
    .word_sel_i  (acc_wsel),
    .word_data_i (acc_wdata),
    .clean_i     (clean)
  );

  assign hit = bus.cpu_req_i && rd_valid && (rd_tag == acc_tag);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    replay_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    line_we     = 1'b0;
    word_we     = 1'b0;
    clean       = 1'b0;
    stall       = 1'b0;
    rdata       = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit) begin
            if (acc_we) word_we = 1'b1;
            else        rdata   = rd_line[32*acc_wsel +: 32];
          end else begin
            stall     = 1'b1;
            addr_d    = acc_addr;
            we_d      = acc_we;
            wdata_d   = acc_wdata;
            mem_req_d = 1'b1;
            if (rd_valid && rd_dirty) begin
              state_d     = WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {rd_tag, acc_idx, {OFF_W{1'b0}}};
              mem_wdata_d = rd_line;
            end else begin
              state_d     = ALLOCATE;
              mem_we_d    = 1'b0;
              mem_addr_d  = {acc_tag, acc_idx, {OFF_W{1'b0}}};
              mem_wdata_d = '0;
            end
          end
        end
      end

      WRITEBACK: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          // Request stays up and is handed straight over to the refill.
          clean       = 1'b1;
          state_d     = ALLOCATE;
          mem_we_d    = 1'b0;
          mem_addr_d  = {acc_tag, acc_idx, {OFF_W{1'b0}}};
          mem_wdata_d = '0;
        end
      end

      ALLOCATE: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          line_we   = 1'b1;
          state_d   = RESUME;
          mem_req_d = 1'b0;
        end
      end

      RESUME: begin
        stall    = 1'b1;
        state_d  = IDLE;
        replay_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      replay_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      replay_q    <= replay_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.cpu_stall_o = stall;
  assign bus.cpu_rdata_o = rdata;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt, wb_evt;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  // The replay hit after RESUME belongs to the miss already counted.
  assign hit_evt  = (state_q == IDLE) && hit && !replay_q;
  assign miss_evt = (state_q == IDLE) && bus.cpu_req_i && !hit;
  assign wb_evt   = miss_evt && rd_valid && rd_dirty;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit_evt  && (hit_cnt_q  != '1)) hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (miss_evt && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    if (wb_evt   && (wb_cnt_q   != '1)) wb_cnt_d   = wb_cnt_q   + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-programmable backing-memory model
// and scoreboards for load data and memory transactions.
module tb_dcache_ctrl;

  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(32), .LINE_BYTES(32)) bus ();

  logic          cpu_req   = 1'b0;
  logic          cpu_we    = 1'b0;
  logic [31:0]   cpu_addr  = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          mem_ack   = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  assign bus.cpu_req_i   = cpu_req;
  assign bus.cpu_we_i    = cpu_we;
  assign bus.cpu_addr_i  = cpu_addr;
  assign bus.cpu_wdata_i = cpu_wdata;
  assign bus.mem_ack_i   = mem_ack;
  assign bus.mem_rdata_i = mem_rdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  dcache_ctrl #(
    .NUM_LINES  (32),
    .LINE_BYTES (32),
    .ADDR_W     (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .wb_cnt_o   (wb_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- backing memory model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        chk;
    int          widx;
    logic [31:0] wval;
  } mexp_t;

  mexp_t         exp_mem[$];
  logic [31:0]   exp_rd[$];
  logic [LW-1:0] mem_lines [logic [31:0]];
  int            lat_rd    = 10;
  int            lat_wb    = 4;
  logic          auto_en   = 1'b1;
  logic          force_ack = 1'b0;
  int            mcnt      = 0;
  mexp_t         mcur;
  logic [LW-1:0] wline;

  function automatic logic [LW-1:0] pattern(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hC0DE_0000 ^ (base + 32'(4 * i));
    return l;
  endfunction

  task automatic exp_push(input logic we, input logic [31:0] addr, input logic chk,
                          input int widx, input logic [31:0] wval);
    mexp_t m;
    m.we = we; m.addr = addr; m.chk = chk; m.widx = widx; m.wval = wval;
    exp_mem.push_back(m);
  endtask

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (auto_en && bus.mem_req_o && !rst) begin
      mcnt++;
      if (mcnt == (bus.mem_we_o ? lat_wb : lat_rd)) begin
        mcnt    = 0;
        mem_ack = 1'b1;
        if (exp_mem.size() == 0) begin
          check("mem_unexpected_req", {224'd0, bus.mem_addr_o}, '1);
        end else begin
          mcur = exp_mem.pop_front();
          check("mem_we", {255'd0, bus.mem_we_o}, {255'd0, mcur.we});
          check("mem_addr", {224'd0, bus.mem_addr_o}, {224'd0, mcur.addr});
          if (mcur.chk) begin
            wline = bus.mem_wdata_o;
            check("mem_wb_word", {224'd0, wline[32*mcur.widx +: 32]}, {224'd0, mcur.wval});
          end
        end
        if (bus.mem_we_o) mem_lines[bus.mem_addr_o] = bus.mem_wdata_o;
        else mem_rdata = mem_lines.exists(bus.mem_addr_o) ? mem_lines[bus.mem_addr_o]
                                                          : pattern(bus.mem_addr_o);
      end
    end else begin
      mcnt = 0;
    end
  end

  // ---------------- CPU access ----------------
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_stall, input logic [31:0] exp_rdata);
    int   stalls = 0;
    logic done   = 1'b0;
    logic [31:0] want;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) exp_rd.push_back(exp_rdata);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check({tag, "_done"}, {255'd0, done}, {255'd0, 1'b1});
    check({tag, "_stall"}, LW'(stalls), LW'(exp_stall));
    if (!we) begin
      want = exp_rd.pop_front();
      check({tag, "_rdata"}, {224'd0, bus.cpu_rdata_o}, {224'd0, want});
    end
    $display("[TB] %s we=%0d addr=%08h stall=%0d rdata=%08h", tag, we, addr, stalls, bus.cpu_rdata_o);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] l100;
    logic          seen;
    l100 = pattern(32'h100);
    l100[31:0] = 32'hDEAD_BEEF;
    mem_lines[32'h100] = l100;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall",  {255'd0, bus.cpu_stall_o}, '0);
    check("rst_req",    {255'd0, bus.mem_req_o}, '0);
    check("rst_we",     {255'd0, bus.mem_we_o}, '0);
    check("rst_addr",   {224'd0, bus.mem_addr_o}, '0);
    check("rst_wdata",  bus.mem_wdata_o, '0);
    check("rst_rdata",  {224'd0, bus.cpu_rdata_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_push(1'b0, 32'h100, 1'b0, 0, 32'h0);
    access("cold_load_100", 1'b0, 32'h100, 32'h0, 12, 32'hDEAD_BEEF);
    access("store_hit_104", 1'b1, 32'h104, 32'h1122_3344, 0, 32'h0);
    access("load_hit_104",  1'b0, 32'h104, 32'h0, 0, 32'h1122_3344);

    exp_push(1'b1, 32'h100, 1'b1, 1, 32'h1122_3344);
    exp_push(1'b0, 32'h500, 1'b0, 0, 32'h0);
    access("dirty_evict_504", 1'b0, 32'h504, 32'h0, 16, 32'hC0DE_0504);

    exp_push(1'b0, 32'h900, 1'b0, 0, 32'h0);
    access("store_miss_900", 1'b1, 32'h900, 32'hA5A5_A5A5, 12, 32'h0);

`ifdef DCACHE_STATS_EN
    check("stats_hit",  {224'd0, hit_cnt},  LW'(2));
    check("stats_miss", {224'd0, miss_cnt}, LW'(3));
    check("stats_wb",   {224'd0, wb_cnt},   LW'(1));
`endif

    access("load_merged_900", 1'b0, 32'h900, 32'h0, 0, 32'hA5A5_A5A5);
    access("load_kept_908",   1'b0, 32'h908, 32'h0, 0, 32'hC0DE_0908);

    exp_push(1'b1, 32'h900, 1'b1, 0, 32'hA5A5_A5A5);
    exp_push(1'b0, 32'h100, 1'b0, 0, 32'h0);
    access("evict_900_load_100", 1'b0, 32'h100, 32'h0, 16, 32'hDEAD_BEEF);
    access("load_hit_104b",      1'b0, 32'h104, 32'h0, 0, 32'h1122_3344);

    // reset while ALLOCATE is outstanding, then a late ack
    auto_en = 1'b0;
    seen    = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_req_o) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rst_alloc_seen",  {255'd0, seen}, {255'd0, 1'b1});
    check("rst_alloc_addr",  {224'd0, bus.mem_addr_o}, {224'd0, 32'h2000});
    check("rst_alloc_we",    {255'd0, bus.mem_we_o}, '0);
    check("rst_alloc_stall", {255'd0, bus.cpu_stall_o}, {255'd0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req",   {255'd0, bus.mem_req_o}, '0);
    check("midrst_stall", {255'd0, bus.cpu_stall_o}, '0);
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(negedge clk);
    check("late_ack_stall", {255'd0, bus.cpu_stall_o}, '0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req",       {255'd0, bus.mem_req_o}, '0);
    check("late_ack_stall_aft", {255'd0, bus.cpu_stall_o}, '0);
    $display("[TB] mid-ALLOCATE reset with late ack done");
    @(posedge clk); #1;
    auto_en = 1'b1;

`ifdef DCACHE_STATS_EN
    check("stats_rst_hit",  {224'd0, hit_cnt},  '0);
    check("stats_rst_miss", {224'd0, miss_cnt}, '0);
    check("stats_rst_wb",   {224'd0, wb_cnt},   '0);
`endif

    exp_push(1'b0, 32'h100, 1'b0, 0, 32'h0);
    access("post_rst_load_100", 1'b0, 32'h100, 32'h0, 12, 32'hDEAD_BEEF);

    exp_push(1'b0, 32'hFFFF_FFE0, 1'b0, 0, 32'h0);
    access("top_addr_load", 1'b0, 32'hFFFF_FFFC, 32'h0, 12, 32'h3F21_FFFC);

    check("mem_queue_empty", LW'(exp_mem.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
